controle_jogo_rodadas: RTL

- Control unit (FSM plus timeout counter) that sequences the memory-game datapath.
- Each round: the player repeats the stored sequence, then enters one new move, which is written to memory.
- Drives the datapath counters, jogada register and memory write enable from datapath status flags.
- Raises ganhou/perdeu/pronto and the timeout indication.

---
 rtl/controle_jogo_rodadas.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/controle_jogo_rodadas.sv
// Control unit for the memory-game datapath: sequences each round (repeat the
// stored sequence, then record one new move) and supervises move timeouts.
module controle_jogo_rodadas #(
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  parameter int unsigned TIMEOUT_W      = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       tem_jogada,
  input  logic       igual,
  input  logic       fim_jogada,
  input  logic       fim_rodada,
  output logic       zera_E,
  output logic       conta_E,
  output logic       zera_R,
  output logic       conta_R,
  output logic       registra_R,
  output logic       escreve_M,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam int unsigned EST_W = 4;
  localparam logic [TIMEOUT_W-1:0] CNT_LIMITE = TIMEOUT_W'(TIMEOUT_CICLOS - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [EST_W-1:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PREPARA_NOVA   = 4'h7,
    ESPERA_NOVA    = 4'h8,
    REGISTRA_NOVA  = 4'h9,
    ESCREVE_NOVA   = 4'hA,
    FIM_GANHOU     = 4'hB,
    FIM_PERDEU     = 4'hC,
    FIM_TIMEOUT    = 4'hD
  } estado_t;

  estado_t              estado_q, estado_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 tem_jogada_q, jogar_q;
  logic                 jogada_ok, ini_ok, expirou, esperando;

  logic zera_e_q, zera_e_d, conta_e_q, conta_e_d;
  logic zera_r_q, zera_r_d, conta_r_q, conta_r_d;
  logic registra_r_q, registra_r_d, escreve_m_q, escreve_m_d;
  logic pronto_q, pronto_d, ganhou_q, ganhou_d;
  logic perdeu_q, perdeu_d, timeout_q, timeout_d;

  // Rising-edge pulses from the level inputs
  assign jogada_ok = tem_jogada & ~tem_jogada_q;
  assign ini_ok    = jogar & ~jogar_q;
  assign expirou   = (cnt_q == CNT_LIMITE);
  assign esperando = (estado_q == ESPERA_JOGADA) || (estado_q == ESPERA_NOVA);

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      INICIAL:        if (ini_ok) estado_d = PREPARACAO;
      PREPARACAO:     estado_d = INICIA_RODADA;
      INICIA_RODADA:  estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada_ok)    estado_d = REGISTRA;
        else if (expirou) estado_d = FIM_TIMEOUT;
      end
      REGISTRA:       estado_d = COMPARA;
      COMPARA: begin
        if (!igual)                    estado_d = FIM_PERDEU;
        else if (!fim_jogada)          estado_d = PROXIMA_JOGADA;
        else if (fim_rodada)           estado_d = FIM_GANHOU;
        else                           estado_d = PREPARA_NOVA;
      end
      PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
      PREPARA_NOVA:   estado_d = ESPERA_NOVA;
      ESPERA_NOVA: begin
        if (jogada_ok)    estado_d = REGISTRA_NOVA;
        else if (expirou) estado_d = FIM_TIMEOUT;
      end
      REGISTRA_NOVA:  estado_d = ESCREVE_NOVA;
      ESCREVE_NOVA:   estado_d = INICIA_RODADA;
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT:
                      if (ini_ok) estado_d = PREPARACAO;
      default:        estado_d = INICIAL;
    endcase
  end

  // Timeout counter: runs only while staying in a wait state, saturates
  always_comb begin
    cnt_d = '0;
    if (esperando && (estado_d == estado_q))
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TIMEOUT_W'(1);
  end

  // Moore decodes of the next state, so registered outputs track the state
  always_comb begin
    zera_e_d     = (estado_d == PREPARACAO) || (estado_d == INICIA_RODADA);
    zera_r_d     = (estado_d == PREPARACAO);
    conta_e_d    = (estado_d == PROXIMA_JOGADA) || (estado_d == PREPARA_NOVA);
    conta_r_d    = (estado_d == ESCREVE_NOVA);
    registra_r_d = (estado_d == REGISTRA) || (estado_d == REGISTRA_NOVA);
    escreve_m_d  = (estado_d == ESCREVE_NOVA);
    pronto_d     = (estado_d == FIM_GANHOU) || (estado_d == FIM_PERDEU) ||
                   (estado_d == FIM_TIMEOUT);
    ganhou_d     = (estado_d == FIM_GANHOU);
    perdeu_d     = (estado_d == FIM_PERDEU) || (estado_d == FIM_TIMEOUT);
    timeout_d    = (estado_d == FIM_TIMEOUT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q     <= INICIAL;
      cnt_q        <= '0;
      tem_jogada_q <= 1'b0;
      jogar_q      <= 1'b0;
      zera_e_q     <= 1'b0;
      zera_r_q     <= 1'b0;
      conta_e_q    <= 1'b0;
      conta_r_q    <= 1'b0;
      registra_r_q <= 1'b0;
      escreve_m_q  <= 1'b0;
      pronto_q     <= 1'b0;
      ganhou_q     <= 1'b0;
      perdeu_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      cnt_q        <= cnt_d;
      tem_jogada_q <= tem_jogada;
      jogar_q      <= jogar;
      zera_e_q     <= zera_e_d;
      zera_r_q     <= zera_r_d;
      conta_e_q    <= conta_e_d;
      conta_r_q    <= conta_r_d;
      registra_r_q <= registra_r_d;
      escreve_m_q  <= escreve_m_d;
      pronto_q     <= pronto_d;
      ganhou_q     <= ganhou_d;
      perdeu_q     <= perdeu_d;
      timeout_q    <= timeout_d;
    end
  end

  assign zera_E     = zera_e_q;
  assign zera_R     = zera_r_q;
  assign conta_E    = conta_e_q;
  assign conta_R    = conta_r_q;
  assign registra_R = registra_r_q;
  assign escreve_M  = escreve_m_q;
  assign pronto     = pronto_q;
  assign ganhou     = ganhou_q;
  assign perdeu     = perdeu_q;
  assign db_timeout = timeout_q;
  assign db_estado  = estado_q;

endmodule
